lsu_data_memory: RTL and testbench
==================================

// Module: lsu_data_memory
// PURPOSE
//  Parametrised load/store data memory for the RV32I core; successor to the LW/SW-only data memory.
//  - Executes LB/LH/LW/LBU/LHU/SB/SH/SW: byte-enable stores, sign/zero-extended loads.
//  - Synchronous-read RAM (DE10-Nano M10K friendly) with a one-entry store buffer.
//  - Byte-masked store-to-load forwarding. Writes results back to the register file port.
// PARAMETERS
//  XLEN        32   data/address width; only 32 is supported.
//  DEPTH_WORDS 256  RAM depth in 32-bit words; must be a power of 2, >= 2.
//  IDX_W       $clog2(DEPTH_WORDS)  word-index width; derived localparam, not overridable.
// PORTS
//  clk                 in   1     core clock
//  reset_n             in   1     asynchronous active-low reset
//  jump_branch_enable  in   1     flush: op sampled this edge becomes a NOP
//  src1_value          in   32    base address register
//  src2_value          in   32    store data
//  imm                 in   32    sign-extended offset
//  rd                  in   5     load destination register
//  operation_con       in   6     opcode from instruction_param.vh; non-memory ops = NOP
//  write_req           out  1     register-file write strobe, one cycle per load
//  write_addr          out  5     register-file index
//  write_data          out  32    aligned and extended load data
//  misalign_fault      out  1     MISALIGN_TRAP_EN only; tied 0 otherwise
// BEHAVIOUR
//  - Reset: write_req, write_addr, write_data, misalign_fault, sb_valid and the load pipe all go to 0.
//    RAM contents are not reset. Reset mid-operation drops the in-flight load and the pending store.
//  - Address: ea = src1_value + imm, mod 2^32.
//    word idx = ea[IDX_W+1:2]; upper bits are dropped, so addresses wrap modulo the RAM size.
//  - Store sampled at edge k:
//    - sb_{addr,data,mask} captured at k; data replicated to its lanes.
//      SB mask = 1<<ea[1:0]; SH mask = 3<<{ea[1],1'b0}; SW mask = 4'hF.
//    - The RAM write happens at edge k+1, byte-enabled by the mask.
//    - Back-to-back stores: buffer drains and refills at the same edge.
//  - Load sampled at edge k:
//    - RAM read at k; rd, ea[1:0] and the opcode are piped.
//    - At edge k+1: write_req=1, write_addr=rd, write_data=extended data. Latency is 2 edges.
//    - Fully pipelined: one load per cycle.
//  - Forwarding:
//    - If sb_valid at edge k and sb_addr==idx, RAM returns old data.
//    - Bytes with sb_mask=1 are taken from sb_data; other bytes come from RAM.
//  - Extension:
//    - LB/LH sign-extend from bit 7/15 of the selected lane.
//    - LBU/LHU zero-extend. LW passes 32 bits.
//  - rd==0: the load executes and write_req still pulses; the register file discards it.
//  - write_req is low on any edge without a completing load.
//  - Flush: jump_branch_enable=1 at edge k stops both the load and the store sampled at k.
//    A store already in the buffer still commits, and an already-piped load still completes.
// CONFIGURATION
//  - `MISALIGN_TRAP_EN defined:
//    - LH/LHU/SH with ea[0]=1, or LW/SW with ea[1:0]!=0, has no RAM, buffer or register-file effect.
//    - misalign_fault pulses 1 at edge k+1, aligned with where write_req would have been.
//  - `MISALIGN_TRAP_EN undefined:
//    - Offending low bits are forced to 0: halfword uses ea[1]; word uses ea[1:0]=0.
//    - misalign_fault is constant 0.
// STRUCTURE
//  - Package lsu_pkg: byte-mask and lane-select functions, load-extend function,
//    and the mem-op subset decode built from the instruction_param.vh opcodes.
//  - Sub-module lsu_bram (DEPTH_WORDS x 32): synchronous read, 4 byte-enables, read-old-data on collision.
//    It is the only inferred memory.
// TESTING
//  1. Flow: SW 0xDEADBEEF @0x10, idle, LW @0x10 rd=5
//     -> 2 edges after the LW: write_req=1, write_addr=5, write_data=0xDEADBEEF.
//  2. Extension: after the SW above:
//     LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
//  3. Forwarding: SW 0x11223344 @0x20, then next cycle SB 0xAA @0x21, then next cycle LW @0x20
//     -> 0x1122AA44.
//  4. Wrap and flush:
//     - DEPTH_WORDS=256: SW 0x5 @0x400, then LW @0x0 -> 0x5.
//     - LW with jump_branch_enable=1 -> no write_req.
//     - Flushed SW @0x0 of 0x9 -> the following LW still reads 0x5.
//  5. Reset: assert reset_n=0 between a load's issue and its completion
//     -> no write_req and all outputs 0; a store issued before reset does not commit.
//  6. Misalign: LW @0x12
//     - With MISALIGN_TRAP_EN: misalign_fault=1, write_req=0.
//     - Without: write_req=1 with the data from word 0x10.

Source files
------------

// File: rtl/lsu_data_memory_pkg.sv
// lsu_pkg: memory-op decode, byte-mask, lane and load-extension helpers for lsu_data_memory.
package lsu_pkg;

  // Memory opcodes of operation_con; every other code is a non-memory op.
  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    mem_size_e size;
    logic      is_unsigned;
  } mem_op_t;

  function automatic mem_op_t decode_mem_op(input logic [5:0] op);
    mem_op_t d;
    d.is_load     = 1'b0;
    d.is_store    = 1'b0;
    d.size        = SZ_WORD;
    d.is_unsigned = 1'b0;
    case (op)
      OP_LB:   begin d.is_load = 1'b1; d.size = SZ_BYTE; end
      OP_LH:   begin d.is_load = 1'b1; d.size = SZ_HALF; end
      OP_LW:   begin d.is_load = 1'b1; d.size = SZ_WORD; end
      OP_LBU:  begin d.is_load = 1'b1; d.size = SZ_BYTE; d.is_unsigned = 1'b1; end
      OP_LHU:  begin d.is_load = 1'b1; d.size = SZ_HALF; d.is_unsigned = 1'b1; end
      OP_SB:   begin d.is_store = 1'b1; d.size = SZ_BYTE; end
      OP_SH:   begin d.is_store = 1'b1; d.size = SZ_HALF; end
      OP_SW:   begin d.is_store = 1'b1; d.size = SZ_WORD; end
      default: d.is_load = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Offending low address bits are forced to zero for the access size.
  function automatic logic [1:0] align_lo(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << {lo[1], 1'b0};
      SZ_WORD: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input mem_size_e sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      SZ_WORD: return d;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] merge_fwd(input logic [31:0] ram, input logic [31:0] sb,
                                            input logic [3:0] mask);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = mask[b] ? sb[8*b +: 8] : ram[8*b +: 8];
    end
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_size_e sz,
                                              input logic [1:0] lo, input logic uns);
    logic [7:0]  bsel;
    logic [15:0] hsel;
    bsel = word[{lo, 3'b000} +: 8];
    hsel = lo[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: return uns ? {24'h000000, bsel} : {{24{bsel[7]}}, bsel};
      SZ_HALF: return uns ? {16'h0000, hsel} : {{16{hsel[15]}}, hsel};
      SZ_WORD: return word;
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_memory_bram.sv
// lsu_bram: DEPTH_WORDS x 32 synchronous-read RAM with byte enables; a colliding read returns old data.
module lsu_bram
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic [3:0]                     i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
  input  logic [31:0]                    i_wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-enabled write and registered read share one edge, so reads see pre-write contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/lsu_data_memory.sv
// lsu_data_memory: RV32I load/store data memory with a one-entry store buffer and byte forwarding.
// Define MISALIGN_TRAP_EN to suppress and flag misaligned halfword/word accesses.
module lsu_data_memory
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            jump_branch_enable,
  input  logic [XLEN-1:0] src1_value,
  input  logic [XLEN-1:0] src2_value,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  input  logic [5:0]      operation_con,
  output logic            write_req,
  output logic [4:0]      write_addr,
  output logic [XLEN-1:0] write_data,
  output logic            misalign_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_op_t          w_dec;
  logic [XLEN-1:0]  w_ea;
  logic [1:0]       w_lo;
  logic [IDX_W-1:0] w_idx;
  logic             w_ld_go;
  logic             w_st_go;
  logic             w_fault_go;
  logic             w_fwd_hit;
  logic [3:0]       w_ram_we;
  logic [31:0]      w_ram_q;
  logic [31:0]      w_merged;
  logic             w_unused_ea;

  logic             r_sb_valid;
  logic [IDX_W-1:0] r_sb_idx;
  logic [31:0]      r_sb_data;
  logic [3:0]       r_sb_mask;
  logic             r_ld_valid;
  logic [4:0]       r_ld_rd;
  logic [1:0]       r_ld_lo;
  mem_size_e        r_ld_size;
  logic             r_ld_uns;
  logic [3:0]       r_fwd_mask;
  logic [31:0]      r_fwd_data;
  logic             r_fault_p;

  // Decode, effective address and issue qualification.
  always_comb begin
    w_dec     = decode_mem_op(operation_con);
    w_ea      = src1_value + imm;
    w_idx     = w_ea[IDX_W+1:2];
    w_lo      = align_lo(w_dec.size, w_ea[1:0]);
    w_fwd_hit = r_sb_valid && (r_sb_idx == w_idx);
`ifdef MISALIGN_TRAP_EN
    w_fault_go = (w_dec.is_load || w_dec.is_store) && !jump_branch_enable &&
                 is_misaligned(w_dec.size, w_ea[1:0]);
`else
    w_fault_go = 1'b0;
`endif
    w_ld_go = w_dec.is_load && !jump_branch_enable && !w_fault_go;
    w_st_go = w_dec.is_store && !jump_branch_enable && !w_fault_go;
  end

  // Address bits above the RAM index only wrap the address space.
  assign w_unused_ea = ^w_ea[XLEN-1:IDX_W+2];

  assign w_ram_we = r_sb_valid ? r_sb_mask : 4'h0;
  assign w_merged = merge_fwd(w_ram_q, r_fwd_data, r_fwd_mask);

  lsu_bram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_sb_idx),
    .i_wdata (r_sb_data),
    .i_raddr (w_idx),
    .o_rdata (w_ram_q)
  );

  // Store buffer, load pipe (with forwarded bytes captured as the RAM reads old data) and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sb_valid     <= 1'b0;
      r_sb_idx       <= '0;
      r_sb_data      <= 32'h0000_0000;
      r_sb_mask      <= 4'h0;
      r_ld_valid     <= 1'b0;
      r_ld_rd        <= 5'd0;
      r_ld_lo        <= 2'b00;
      r_ld_size      <= SZ_BYTE;
      r_ld_uns       <= 1'b0;
      r_fwd_mask     <= 4'h0;
      r_fwd_data     <= 32'h0000_0000;
      r_fault_p      <= 1'b0;
      write_req      <= 1'b0;
      write_addr     <= 5'd0;
      write_data     <= '0;
      misalign_fault <= 1'b0;
    end else begin
      r_sb_valid <= w_st_go;
      if (w_st_go) begin
        r_sb_idx  <= w_idx;
        r_sb_data <= store_lanes(w_dec.size, src2_value);
        r_sb_mask <= byte_mask(w_dec.size, w_lo);
      end else begin
        r_sb_idx  <= r_sb_idx;
        r_sb_data <= r_sb_data;
        r_sb_mask <= r_sb_mask;
      end

      r_ld_valid <= w_ld_go;
      r_ld_rd    <= rd;
      r_ld_lo    <= w_lo;
      r_ld_size  <= w_dec.size;
      r_ld_uns   <= w_dec.is_unsigned;
      r_fwd_mask <= w_fwd_hit ? r_sb_mask : 4'h0;
      r_fwd_data <= r_sb_data;
      r_fault_p  <= w_fault_go;

      write_req      <= r_ld_valid;
      misalign_fault <= r_fault_p;
      if (r_ld_valid) begin
        write_addr <= r_ld_rd;
        write_data <= load_extend(w_merged, r_ld_size, r_ld_lo, r_ld_uns);
      end else begin
        write_addr <= write_addr;
        write_data <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_data_memory.sv
// tb_lsu_data_memory: directed and randomized checks of lsu_data_memory against a byte-array memory model.
module tb_lsu_data_memory;
  import lsu_pkg::*;

  localparam int DEPTH  = 256;
  localparam int NBYTES = DEPTH * 4;

  logic        clk;
  logic        reset_n;
  logic        jump_branch_enable;
  logic [31:0] src1_value;
  logic [31:0] src2_value;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [5:0]  operation_con;
  logic        write_req;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        misalign_fault;

  typedef struct packed {
    logic        req;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  int   n_checks;
  int   n_fail;
  exp_t pend;
  exp_t chk;
  logic [7:0] mdl [NBYTES];

  lsu_data_memory #(
    .XLEN(32),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .jump_branch_enable (jump_branch_enable),
    .src1_value         (src1_value),
    .src2_value         (src2_value),
    .imm                (imm),
    .rd                 (rd),
    .operation_con      (operation_con),
    .write_req          (write_req),
    .write_addr         (write_addr),
    .write_data         (write_data),
    .misalign_fault     (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequential program-order model: each op acts on a flat little-endian byte memory.
  function automatic exp_t model_op(input logic [5:0] op, input logic [31:0] ea,
                                    input logic [31:0] data, input logic [4:0] rdv,
                                    input logic flush);
    exp_t        e;
    int          n;
    bit          ld;
    bit          uns;
    logic [31:0] a;
    logic [31:0] v;
    int          b;
    e = '0;
    ld = 1'b1;
    uns = 1'b0;
    case (op)
      OP_LB:   n = 1;
      OP_LBU:  begin n = 1; uns = 1'b1; end
      OP_LH:   n = 2;
      OP_LHU:  begin n = 2; uns = 1'b1; end
      OP_LW:   n = 4;
      OP_SB:   begin n = 1; ld = 1'b0; end
      OP_SH:   begin n = 2; ld = 1'b0; end
      OP_SW:   begin n = 4; ld = 1'b0; end
      default: n = 0;
    endcase
    if (n == 0 || flush) return e;
`ifdef MISALIGN_TRAP_EN
    if ((int'(ea[1:0]) % n) != 0) begin
      e.fault = 1'b1;
      return e;
    end
`endif
    a = ea & ~(32'(n - 1));
    b = int'(a % 32'(NBYTES));
    if (!ld) begin
      for (int i = 0; i < n; i++) mdl[b + i] = data[8*i +: 8];
      return e;
    end
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[b + i];
    if (!uns && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    e.req  = 1'b1;
    e.addr = rdv;
    e.data = v;
    return e;
  endfunction

  // Drive one op, advance one edge; chk then holds the expectation for the visible outputs.
  task automatic issue(input logic [5:0] op, input logic [31:0] base, input logic [31:0] immv,
                       input logic [31:0] data, input logic [4:0] rdv, input logic flush);
    exp_t e;
    operation_con      = op;
    src1_value         = base;
    imm                = immv;
    src2_value         = data;
    rd                 = rdv;
    jump_branch_enable = flush;
    e = model_op(op, base + immv, data, rdv, flush);
    @(posedge clk);
    #1;
    chk  = pend;
    pend = e;
    operation_con      = OP_NOP;
    jump_branch_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (write_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", write_req); end
    n_checks++; if (write_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", write_addr); end
    n_checks++; if (write_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", write_data); end
    n_checks++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", misalign_fault); end
    reset_n = 1'b1;
    pend = '0;
    chk  = '0;
  endtask

  task automatic test_flow();
    issue(OP_SW, 32'h10, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0);
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    issue(OP_LW, 32'h8, 32'h8, 32'h0, 5'd5, 1'b0);
    n_checks++; if (write_req !== 1'b0) begin n_fail++; $display("FAIL flow_early_req got=%b exp=0", write_req); end
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++; if (write_req !== 1'b1) begin n_fail++; $display("FAIL flow_req got=%b exp=1", write_req); end
    n_checks++; if (write_addr !== 5'd5) begin n_fail++; $display("FAIL flow_addr got=%0d exp=5", write_addr); end
    n_checks++; if (write_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL flow_data got=%h exp=deadbeef", write_data); end
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++; if (write_req !== 1'b0) begin n_fail++; $display("FAIL flow_single_pulse got=%b exp=0", write_req); end
  endtask

  task automatic test_extension();
    logic [5:0]  ops [4];
    logic [31:0] offs [4];
    logic [31:0] exps [4];
    ops  = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
    offs = '{32'h3, 32'h3, 32'h0, 32'h2};
    exps = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_BEEF, 32'h0000_DEAD};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) issue(ops[i], 32'h10, offs[i], 32'h0, 5'(i + 1), 1'b0);
      else       issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      if (i > 0) begin
        n_checks++;
        if (write_req !== 1'b1 || write_addr !== 5'(i) || write_data !== exps[i-1]) begin
          n_fail++;
          $display("FAIL ext_%0d got req=%b rd=%0d data=%h exp req=1 rd=%0d data=%h",
                   i - 1, write_req, write_addr, write_data, i, exps[i-1]);
        end
      end
    end
  endtask

  task automatic test_forwarding();
    issue(OP_SW, 32'h20, 32'h0, 32'h1122_3344, 5'd0, 1'b0);
    issue(OP_SB, 32'h20, 32'h1, 32'h5555_55AA, 5'd0, 1'b0);
    issue(OP_LW, 32'h20, 32'h0, 32'h0, 5'd7, 1'b0);
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++; if (write_req !== 1'b1) begin n_fail++; $display("FAIL fwd_req got=%b exp=1", write_req); end
    n_checks++; if (write_data !== 32'h1122_AA44) begin n_fail++; $display("FAIL fwd_data got=%h exp=1122aa44", write_data); end
  endtask

  task automatic test_wrap_flush();
    issue(OP_SW, 32'h3FC, 32'h4, 32'h5, 5'd0, 1'b0);
    issue(OP_LW, 32'h0, 32'h0, 32'h0, 5'd9, 1'b0);
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++; if (write_req !== 1'b1 || write_data !== 32'h5) begin n_fail++; $display("FAIL wrap_data got req=%b data=%h exp req=1 data=5", write_req, write_data); end
    issue(OP_LW, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1);
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++; if (write_req !== 1'b0) begin n_fail++; $display("FAIL flush_load_req got=%b exp=0", write_req); end
    issue(OP_SW, 32'h0, 32'h0, 32'h9, 5'd0, 1'b1);
    issue(OP_LW, 32'h0, 32'h0, 32'h0, 5'd10, 1'b0);
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++; if (write_req !== 1'b1 || write_data !== 32'h5) begin n_fail++; $display("FAIL flush_store_data got req=%b data=%h exp req=1 data=5", write_req, write_data); end
  endtask

  task automatic test_reset_midop();
    issue(OP_LW, 32'h10, 32'h0, 32'h0, 5'd3, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (write_req !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'h0 || misalign_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset_outputs got req=%b rd=%0d data=%h fault=%b exp all 0",
               write_req, write_addr, write_data, misalign_fault);
    end
    #2 reset_n = 1'b1;
    pend = '0;
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++; if (write_req !== 1'b0) begin n_fail++; $display("FAIL midop_load_dropped got=%b exp=0", write_req); end
    issue(OP_SW, 32'h10, 32'h0, 32'h7777_7777, 5'd0, 1'b0);
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    pend = '0;
    void'(model_op(OP_SW, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0));
    issue(OP_LW, 32'h10, 32'h0, 32'h0, 5'd4, 1'b0);
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++; if (write_req !== 1'b1 || write_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL midop_store_dropped got req=%b data=%h exp req=1 data=deadbeef", write_req, write_data); end
  endtask

  task automatic test_misalign();
    issue(OP_LW, 32'h10, 32'h2, 32'h0, 5'd6, 1'b0);
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    n_checks++; if (misalign_fault !== 1'b1) begin n_fail++; $display("FAIL misalign_fault got=%b exp=1", misalign_fault); end
    n_checks++; if (write_req !== 1'b0) begin n_fail++; $display("FAIL misalign_req got=%b exp=0", write_req); end
    issue(OP_SH, 32'h11, 32'h0, 32'h0, 5'd0, 1'b0);
    issue(OP_LW, 32'h10, 32'h0, 32'h0, 5'd6, 1'b0);
    issue(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++; if (write_data !== 32'hDEAD_BEEF || misalign_fault !== 1'b0) begin n_fail++; $display("FAIL misalign_store_blocked got data=%h fault=%b exp data=deadbeef fault=0", write_data, misalign_fault); end
`else
    n_checks++; if (write_req !== 1'b1 || write_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL misalign_forced got req=%b data=%h exp req=1 data=deadbeef", write_req, write_data); end
    n_checks++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL misalign_fault_tied got=%b exp=0", misalign_fault); end
`endif
  endtask

  task automatic test_random();
    logic [5:0]  ops_all [9];
    logic [31:0] ea_t;
    logic [31:0] base;
    ops_all = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_NOP};
    for (int w = 0; w < 64; w++) issue(OP_SW, 32'(w * 4), 32'h0, $urandom, 5'd0, 1'b0);
    for (int it = 0; it < 400; it++) begin
      ea_t = 32'($urandom_range(0, 255));
      base = $urandom;
      issue(ops_all[$urandom_range(0, 8)], base,
            ea_t - base + 32'h400 * 32'($urandom_range(0, 3)),
            $urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
      n_checks++;
      if (write_req !== chk.req || misalign_fault !== chk.fault ||
          (chk.req && (write_addr !== chk.addr || write_data !== chk.data))) begin
        n_fail++;
        $display("FAIL rand_%0d got req=%b rd=%0d data=%h fault=%b exp req=%b rd=%0d data=%h fault=%b",
                 it, write_req, write_addr, write_data, misalign_fault,
                 chk.req, chk.addr, chk.data, chk.fault);
      end
    end
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    pend               = '0;
    chk                = '0;
    reset_n            = 1'b0;
    jump_branch_enable = 1'b0;
    src1_value         = 32'h0;
    src2_value         = 32'h0;
    imm                = 32'h0;
    rd                 = 5'd0;
    operation_con      = OP_NOP;
    test_reset();
    test_flow();
    test_extension();
    test_forwarding();
    test_wrap_flush();
    test_reset_midop();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
